axi4_slave_read_addr_queue: RTL
===============================

Name: axi4_slave_read_addr_queue

Overview:
- Upstream neighbour of the AXI4 slave read-data stage; owns the AR channel.
- Accepts AR handshakes into a small request FIFO and checks each request against AXI4 rules.
- Precomputes WRAP boundary and upper limit so the read-data stage never divides.
- Presents one request at a time through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, R data bus width in bits; power of 2, range 8..1024.
- ADDR_WIDTH, 32, address width; minimum 13.
- ID_WIDTH, 4, AXI ID width.
- FIFO_DEPTH, 2, request queue depth; power of 2, minimum 2.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset; asynchronous, active-high.
- arid  input  ID_WIDTH  AR ID.
- araddr  input  ADDR_WIDTH  AR start address.
- arlen  input  8  beats minus 1.
- arsize  input  3  log2 bytes per beat.
- arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- arvalid  input  1  AR valid.
- arready  output  1  AR ready; registered.
- req_valid  output  1  head entry available.
- req_ready  input  1  read-data stage takes head.
- req_id  output  ID_WIDTH  head ID.
- req_addr  output  ADDR_WIDTH  head start address.
- req_len  output  8  head arlen.
- req_size  output  3  head arsize.
- req_burst  output  2  head arburst.
- req_wrap_base  output  ADDR_WIDTH  WRAP lower boundary; equals req_addr for non-WRAP.
- req_wrap_limit  output  ADDR_WIDTH  last beat address before wrap; 0 for non-WRAP.
- req_err  output  1  head request illegal; downstream returns SLVERR (2'b10) on every beat.
- q_count  output  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, sync release): storage contents are don't-care.
  - Reset values: arready=0, req_valid=0, q_count=0, all req_* outputs=0.
- arready:
  - Registered; rises on the first clk edge after rst deasserts.
  - Next value = (count_next < FIFO_DEPTH).
  - At most one AR accept per cycle.
- Push: arvalid && arready.
  - Write fields plus computed wrap_base, wrap_limit and err at wptr.
  - Advance wptr modulo FIFO_DEPTH.
- Pop: req_valid && req_ready; advance rptr.
- Occupancy and flags:
  - count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - req_valid = (count != 0).
  - req_* outputs are driven combinationally from entry[rptr], stable while req_valid && !req_ready.
- Latency:
  - AR handshake in cycle N gives req_valid=1 in cycle N+1 when the queue was empty.
  - Full queue: pop in cycle N gives arready=1 in cycle N+1.
- Full queue: arready=0; arvalid holds with no loss and no overwrite.
- Empty queue: req_ready is ignored; pointers do not move.
- Pointer wrap-around: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count disambiguates full from empty.
- WRAP arithmetic (no divider):
  - bytes = (arlen+1) << arsize, at least ADDR_WIDTH+1 bits wide.
  - wrap_base = araddr & ~(bytes-1).
  - wrap_limit = wrap_base + bytes - (1<<arsize).
- Reset mid-operation:
  - Queue is emptied immediately.
  - In-flight entries are discarded; no req_valid after release until a new push.

Optional Feature:
- Macro: AXI_AR_PROTOCOL_CHECK_EN.
- Defined: err=1 when any of the following holds.
  - arburst==11.
  - arsize > log2(DATA_WIDTH/8).
  - WRAP with arlen not in {1,3,7,15}.
  - WRAP with araddr not aligned to 1<<arsize.
  - INCR with araddr[11:0] + ((arlen+1)<<arsize) > 4096 (4KB crossing).
  - An erroneous request is still queued and handshaked normally; only req_err differs.
- Undefined: req_err tied 0; no check logic is synthesised; req_wrap_base/limit are still computed.

Test Plan:
- Release reset, arvalid=1 with id=3, addr=0x100, len=3, size=2, INCR. Expect arready=1 one cycle after release; req_valid=1 the next cycle with req_addr=0x100, req_len=3, req_err=0.
- WRAP: addr=0x1C, len=3, size=2. Expect req_wrap_base=0x10, req_wrap_limit=0x1C.
- Hold req_ready=0 and push 2 requests (DEPTH=2). Expect q_count=2 and arready=0; a third arvalid stalls. Pulse req_ready for 1 cycle: head pops, arready=1 next cycle, third request accepted, FIFO order preserved by ID.
- Push and pop in the same cycle at count=1. Expect count stays 1, new entry appears behind the head, no data corruption.
- With AXI_AR_PROTOCOL_CHECK_EN defined:
  - INCR addr=0xFF8, len=3, size=2 gives req_err=1.
  - WRAP len=2 gives req_err=1.
  - arburst=11 gives req_err=1.
  - Without the macro, the same stimuli give req_err=0.
- Assert rst with 2 entries queued. Expect req_valid=0, q_count=0 and arready=0 immediately; after release only new requests emerge.

Source files
------------

// File: rtl/axi4_slave_read_addr_queue.sv
// AXI4 slave AR channel request queue with precomputed WRAP bounds.
// Optional protocol checking is built when AXI_AR_PROTOCOL_CHECK_EN is defined.
module axi4_slave_read_addr_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ID_WIDTH-1:0]           arid,
    input  logic [ADDR_WIDTH-1:0]         araddr,
    input  logic [7:0]                    arlen,
    input  logic [2:0]                    arsize,
    input  logic [1:0]                    arburst,
    input  logic                          arvalid,
    output logic                          arready,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [ID_WIDTH-1:0]           req_id,
    output logic [ADDR_WIDTH-1:0]         req_addr,
    output logic [7:0]                    req_len,
    output logic [2:0]                    req_size,
    output logic [1:0]                    req_burst,
    output logic [ADDR_WIDTH-1:0]         req_wrap_base,
    output logic [ADDR_WIDTH-1:0]         req_wrap_limit,
    output logic                          req_err,
    output logic [$clog2(FIFO_DEPTH):0]   q_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    // wide enough for 256 beats of 128 bytes and for any address
    localparam int BW = (ADDR_WIDTH + 1 > 17) ? ADDR_WIDTH + 1 : 17;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [ID_WIDTH-1:0]   mem_id    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr  [FIFO_DEPTH];
    logic [7:0]            mem_len   [FIFO_DEPTH];
    logic [2:0]            mem_size  [FIFO_DEPTH];
    logic [1:0]            mem_burst [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_base  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_limit [FIFO_DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    logic                  is_wrap;
    logic [BW-1:0]         bytes;
    logic [BW-1:0]         mask_w;
    logic [BW-1:0]         beat_w;
    logic [ADDR_WIDTH-1:0] wrap_base_c;
    logic [ADDR_WIDTH-1:0] wrap_limit_c;
    logic                  unused_ok;

    assign push       = arvalid && arready;
    assign req_valid  = (count != '0);
    assign pop        = req_valid && req_ready;
    assign count_next = count + CW'(push) - CW'(pop);
    assign q_count    = count;

    // burst footprint and WRAP window by masking, never dividing
    assign is_wrap = (arburst == 2'b10);
    assign bytes   = BW'(9'(arlen) + 9'd1) << arsize;
    assign beat_w  = BW'(1) << arsize;
    assign mask_w  = bytes - BW'(1);

    assign wrap_base_c = is_wrap
        ? (araddr & ~mask_w[ADDR_WIDTH-1:0])
        : araddr;
    assign wrap_limit_c = is_wrap
        ? (wrap_base_c + bytes[ADDR_WIDTH-1:0] - beat_w[ADDR_WIDTH-1:0])
        : '0;

    assign unused_ok = ^{bytes[BW-1:ADDR_WIDTH],
                         mask_w[BW-1:ADDR_WIDTH],
                         beat_w[BW-1:ADDR_WIDTH],
                         (DATA_WIDTH > 8)};

`ifdef AXI_AR_PROTOCOL_CHECK_EN
    localparam logic [2:0] MAXSIZE = 3'($clog2(DATA_WIDTH / 8));

    logic mem_err [FIFO_DEPTH];
    logic bad_burst;
    logic bad_size;
    logic bad_len;
    logic bad_align;
    logic bad_4k;
    logic err_c;

    assign bad_burst = (arburst == 2'b11);
    assign bad_size  = (arsize > MAXSIZE);
    assign bad_len   = is_wrap &&
        !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15});
    assign bad_align = is_wrap &&
        ((araddr[7:0] & (beat_w[7:0] - 8'd1)) != 8'd0);
    assign bad_4k    = (arburst == 2'b01) &&
        ((BW'(araddr[11:0]) + bytes) > BW'(4096));
    assign err_c = bad_burst | bad_size | bad_len | bad_align | bad_4k;

    // error flag travels with its entry
    always_ff @(posedge clk) begin
        if (push) begin
            mem_err[wptr] <= err_c;
        end
    end

    assign req_err = req_valid & mem_err[rptr];
`else
    assign req_err = 1'b0;
`endif

    // entry storage; contents are meaningless while the slot is free
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wptr]    <= arid;
            mem_addr[wptr]  <= araddr;
            mem_len[wptr]   <= arlen;
            mem_size[wptr]  <= arsize;
            mem_burst[wptr] <= arburst;
            mem_base[wptr]  <= wrap_base_c;
            mem_limit[wptr] <= wrap_limit_c;
        end
    end

    // pointers, occupancy and registered AR ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            arready <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count   <= count_next;
            arready <= (count_next < DEPTH_C);
        end
    end

    // head entry, forced to zero when the queue is empty
    always_comb begin
        req_id         = '0;
        req_addr       = '0;
        req_len        = '0;
        req_size       = '0;
        req_burst      = '0;
        req_wrap_base  = '0;
        req_wrap_limit = '0;
        if (req_valid) begin
            req_id         = mem_id[rptr];
            req_addr       = mem_addr[rptr];
            req_len        = mem_len[rptr];
            req_size       = mem_size[rptr];
            req_burst      = mem_burst[rptr];
            req_wrap_base  = mem_base[rptr];
            req_wrap_limit = mem_limit[rptr];
        end
    end

endmodule
